weight_fetch: RTL and testbench



---
 rtl/weight_fetch_pkg.sv | 28 ++
 rtl/weight_fetch_if.sv | 16 +
 rtl/wf_beat_fifo.sv | 64 ++++++
 rtl/weight_fetch.sv | 152 +++++++++++++++
 tb/tb_weight_fetch.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_fetch_pkg.sv
// Shared constants, FSM state encoding and beat-geometry helpers for the weight ROM sequencer.
package weight_fetch_pkg;

    localparam int W_WIDTH          = 16;
    localparam int WEIGHTS_PER_WORD = 8;
    localparam int BEAT_WEIGHTS     = 2 * WEIGHTS_PER_WORD;
    localparam int COUNT_W          = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int calc_nwords(input int num_weights);
        return (num_weights + WEIGHTS_PER_WORD - 1) / WEIGHTS_PER_WORD;
    endfunction

    // A beat carries two consecutive ROM words.
    function automatic int calc_nbeats(input int num_weights);
        return (calc_nwords(num_weights) + 1) / 2;
    endfunction

    function automatic int calc_last_count(input int num_weights);
        return num_weights - BEAT_WEIGHTS * (calc_nbeats(num_weights) - 1);
    endfunction

endpackage

// File: rtl/weight_fetch_if.sv
// Valid/ready beat stream from the weight sequencer to the MAC array.
interface weight_fetch_if #(
    parameter int DATA_WIDTH = 128
);
    import weight_fetch_pkg::*;

    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic                    out_last;
    logic [COUNT_W-1:0]      out_count;

    modport master (output out_valid, out_data, out_last, out_count, input out_ready);
    modport slave  (input out_valid, out_data, out_last, out_count, output out_ready);

endinterface

// File: rtl/wf_beat_fifo.sv
// Synchronous beat buffer; accepts a push while full when a pop happens in the same cycle.
module wf_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so a reset shows all-zero beat fields rather than stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

endmodule

// File: rtl/weight_fetch.sv
// Dual-port weight ROM sequencer streaming 2-word beats. Optional WEIGHT_FETCH_ZERO_MASK_EN
// zeroes lanes past out_count on the final beat.
module weight_fetch
    import weight_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 16,
    parameter int NUM_WEIGHTS = 122,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    weight_fetch_if.master        out_if
);
    localparam int NWORDS     = calc_nwords(NUM_WEIGHTS);
    localparam int LAST_WORD  = (NWORDS < DEPTH) ? NWORDS - 1 : DEPTH - 1;
    localparam int NBEATS     = calc_nbeats(NUM_WEIGHTS);
    localparam int LAST_COUNT = calc_last_count(NUM_WEIGHTS);
    localparam int KW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_W     = 2 * DATA_WIDTH;
    localparam int ENTRY_W    = BEAT_W + 1 + COUNT_W;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    state_e                state_q;
    logic [KW-1:0]         k_q;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
    logic [ADDR_WIDTH-1:0] addr_a_d, addr_b_d;
    logic                  iss_v_q, iss_last_q;
    logic                  rom_v_q, rom_last_q;
    logic                  busy_q, done_q;
    logic                  is_last_k, issue_ok, issue;
    logic                  pop, last_hs, fifo_empty;
    logic [OCC_W-1:0]      occupancy;
    logic [BEAT_W-1:0]     beat_data;
    logic [COUNT_W-1:0]    beat_count;
    logic [ENTRY_W-1:0]    fifo_wdata, fifo_rdata;

    // NOTE: defaults first so no path leaves a combinational signal unassigned (no latch).
    always_comb begin
        addr_a_d = ADDR_WIDTH'(2 * int'(k_q));
        addr_b_d = addr_a_d;
        if (2 * int'(k_q) + 1 <= LAST_WORD) begin
            addr_b_d = ADDR_WIDTH'(2 * int'(k_q) + 1);
        end
    end

    // Buffered beats plus pairs still in the ROM/capture pipe must fit the FIFO.
    assign is_last_k = (k_q == KW'(NBEATS - 1));
    assign issue_ok  = (int'(occupancy) + int'(iss_v_q) + int'(rom_v_q)) < FIFO_DEPTH;
    assign issue     = ((state_q == IDLE) && start) || ((state_q == FETCH) && issue_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            iss_v_q    <= 1'b0;
            iss_last_q <= 1'b0;
            rom_v_q    <= 1'b0;
            rom_last_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            iss_v_q    <= 1'b0;
            iss_last_q <= 1'b0;
            rom_v_q    <= iss_v_q;
            rom_last_q <= iss_last_q;
            done_q     <= 1'b0;
            if (issue) begin
                addr_a_q   <= addr_a_d;
                addr_b_q   <= addr_b_d;
                iss_v_q    <= 1'b1;
                iss_last_q <= is_last_k;
                k_q        <= is_last_k ? '0 : k_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= is_last_k ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (issue_ok && is_last_k) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat_count = rom_last_q ? COUNT_W'(LAST_COUNT) : COUNT_W'(BEAT_WEIGHTS);

`ifdef WEIGHT_FETCH_ZERO_MASK_EN
    always_comb begin
        beat_data = {q_a, q_b};
        if (rom_last_q) begin
            for (int j = LAST_COUNT; j < BEAT_WEIGHTS; j++) begin
                beat_data[BEAT_W-1-j*W_WIDTH -: W_WIDTH] = '0;
            end
        end
    end
`else
    assign beat_data = {q_a, q_b};
`endif

    assign fifo_wdata = {beat_data, rom_last_q, beat_count};
    assign pop        = out_if.out_valid & out_if.out_ready;

    wf_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rom_v_q),
        .wdata_i     (fifo_wdata),
        .pop_i       (pop),
        .rdata_o     (fifo_rdata),
        .empty_o     (fifo_empty),
        .occupancy_o (occupancy)
    );

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_data  = fifo_rdata[ENTRY_W-1 -: BEAT_W];
    assign out_if.out_last  = ~fifo_empty & fifo_rdata[COUNT_W];
    assign out_if.out_count = fifo_empty ? '0 : fifo_rdata[COUNT_W-1:0];
    assign last_hs          = pop & out_if.out_last;

    assign busy   = busy_q;
    assign done   = done_q;
    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: timing, backpressure patterns, start-while-busy and mid-pass reset.
`timescale 1ns/1ps
module tb_weight_fetch;

    localparam int NBEATS = 8;

    typedef struct {
        logic [255:0] data;
        logic         last;
        logic [4:0]   count;
        int           edge_n;
    } beat_rec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         busy;
    logic         done;
    logic [3:0]   addr_a;
    logic [3:0]   addr_b;
    logic [127:0] q_a;
    logic [127:0] q_b;
    logic [127:0] rom [16];

    int        n_checks   = 0;
    int        n_errors   = 0;
    int        cyc        = 0;
    int        done_cnt   = 0;
    int        done_cyc   = 0;
    int        ready_mode = 3;
    beat_rec_t beats_q[$];
    beat_rec_t hs_rec;
    bit        hs_pend    = 1'b0;
    bit        stall_q    = 1'b0;
    beat_rec_t stall_rec;

    weight_fetch_if #(.DATA_WIDTH(128)) wf_if ();

    weight_fetch #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (128),
        .DEPTH       (16),
        .NUM_WEIGHTS (122),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .q_a    (q_a),
        .q_b    (q_b),
        .out_if (wf_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        q_a <= rom[addr_a];
        q_b <= rom[addr_b];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_beat(input int k);
        logic [255:0] b;
        b = {rom[2*k], rom[2*k+1]};
`ifdef WEIGHT_FETCH_ZERO_MASK_EN
        if (k == NBEATS - 1) begin
            for (int j = 10; j < 16; j++) begin
                b[255 - j*16 -: 16] = 16'h0000;
            end
        end
`endif
        return b;
    endfunction

    // Consumer ready pattern: 0 always, 1 toggle, 2 random ~70% high, 3 held low.
    initial begin
        wf_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wf_if.out_ready = 1'b1;
                1:       wf_if.out_ready = ~wf_if.out_ready;
                2:       wf_if.out_ready = ($urandom_range(0, 99) < 70);
                default: wf_if.out_ready = 1'b0;
            endcase
        end
    end

    // Edge counter and handshake commit; a handshake seen at negedge only lands if reset stays high.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (hs_pend && rst_n) begin
                hs_rec.edge_n = cyc;
                beats_q.push_back(hs_rec);
            end
            hs_pend = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (stall_q && wf_if.out_valid) begin
                check("stall_data",  wf_if.out_data, stall_rec.data);
                check("stall_last",  256'(wf_if.out_last), 256'(stall_rec.last));
                check("stall_count", 256'(wf_if.out_count), 256'(stall_rec.count));
            end
            stall_q         = wf_if.out_valid & ~wf_if.out_ready;
            stall_rec.data  = wf_if.out_data;
            stall_rec.last  = wf_if.out_last;
            stall_rec.count = wf_if.out_count;
            hs_pend         = wf_if.out_valid & wf_if.out_ready;
            hs_rec.data     = wf_if.out_data;
            hs_rec.last     = wf_if.out_last;
            hs_rec.count    = wf_if.out_count;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_reset(input string name);
        check({name, "_busy"},      256'(busy), 256'(0));
        check({name, "_done"},      256'(done), 256'(0));
        check({name, "_addr_a"},    256'(addr_a), 256'(0));
        check({name, "_addr_b"},    256'(addr_b), 256'(0));
        check({name, "_out_valid"}, 256'(wf_if.out_valid), 256'(0));
        check({name, "_out_last"},  256'(wf_if.out_last), 256'(0));
        check({name, "_out_count"}, 256'(wf_if.out_count), 256'(0));
        check({name, "_out_data"},  wf_if.out_data, 256'(0));
    endtask

    task automatic run_pass(input string name, input int mode, input bit timing,
                            input bit restart, input int stall);
        int t;
        int waited;
        beats_q.delete();
        done_cnt   = 0;
        ready_mode = (stall > 0) ? 3 : mode;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = cyc;
        check({name, "_busy_start"}, 256'(busy), 256'(1));
        if (timing) begin
            check({name, "_addr_a0"}, 256'(addr_a), 256'(0));
            check({name, "_addr_b0"}, 256'(addr_b), 256'(1));
        end
        if (stall > 0) begin
            repeat (stall - 1) @(posedge clk);
            #1;
            check({name, "_addr_a_held"}, 256'(addr_a), 256'(6));
            check({name, "_addr_b_held"}, 256'(addr_b), 256'(7));
            check({name, "_valid_held"},  256'(wf_if.out_valid), 256'(1));
            check({name, "_no_beats"},    256'(beats_q.size()), 256'(0));
            ready_mode = mode;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
            start = (restart && waited == 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({name, "_done_seen"}, 256'(done_cnt != 0), 256'(1));
        repeat (12) @(posedge clk);
        #1;
        check({name, "_done_count"}, 256'(done_cnt), 256'(1));
        check({name, "_beat_total"}, 256'(beats_q.size()), 256'(NBEATS));
        check({name, "_busy_end"},   256'(busy), 256'(0));
        for (int k = 0; k < beats_q.size() && k < NBEATS; k++) begin
            check($sformatf("%s_b%0d_data", name, k), beats_q[k].data, exp_beat(k));
            check($sformatf("%s_b%0d_last", name, k), 256'(beats_q[k].last),
                  256'(k == NBEATS - 1));
            check($sformatf("%s_b%0d_count", name, k), 256'(beats_q[k].count),
                  (k == NBEATS - 1) ? 256'(10) : 256'(16));
            if (timing) begin
                check($sformatf("%s_b%0d_edge", name, k), 256'(beats_q[k].edge_n),
                      256'(t + 3 + k));
            end
        end
        if (timing) begin
            check({name, "_done_cycle"}, 256'(done_cyc), 256'(t + 10));
        end
        if (beats_q.size() == NBEATS) begin
            check({name, "_b0_upper"}, 256'(beats_q[0].data[255:128]),
                  256'(128'hf9e0fe01f8b3fde3fe94fd4ffff6fbe9));
            check({name, "_b7_lane8"}, 256'(beats_q[7].data[127:112]), 256'(16'h1234));
            check({name, "_b7_lane9"}, 256'(beats_q[7].data[111:96]),  256'(16'h5678));
`ifdef WEIGHT_FETCH_ZERO_MASK_EN
            check({name, "_b7_lane10"}, 256'(beats_q[7].data[95:80]), 256'(16'h0000));
            check({name, "_b7_lane15"}, 256'(beats_q[7].data[15:0]),  256'(16'h0000));
`else
            check({name, "_b7_lane10"}, 256'(beats_q[7].data[95:80]), 256'(16'hdead));
            check({name, "_b7_lane15"}, 256'(beats_q[7].data[15:0]),  256'(16'hdead));
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        start = 1'b0;
        rom[0] = 128'hf9e0fe01f8b3fde3fe94fd4ffff6fbe9;
        for (int i = 1; i < 15; i++) begin
            for (int m = 0; m < 8; m++) begin
                rom[i][127 - 16*m -: 16] = 16'((i << 8) | (m << 4) | 5);
            end
        end
        rom[15] = {16'h1234, 16'h5678, {6{16'hdead}}};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_pass("single",  0, 1'b1, 1'b0, 0);
        run_pass("toggle",  1, 1'b0, 1'b0, 0);
        run_pass("random",  2, 1'b0, 1'b0, 0);
        run_pass("stall",   0, 1'b0, 1'b0, 20);
        run_pass("restart", 1, 1'b0, 1'b1, 0);

        // Reset while beat 4 is mid-handshake: nothing further may land and no done may pulse.
        beats_q.delete();
        done_cnt   = 0;
        ready_mode = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        while (beats_q.size() < 4 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("midrst_beats_before", 256'(beats_q.size()), 256'(4));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done",     256'(done_cnt), 256'(0));
        check("midrst_beats_after", 256'(beats_q.size()), 256'(4));
        if (beats_q.size() >= 4) begin
            check("midrst_b3_data", beats_q[3].data, exp_beat(3));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_pass("replay", 0, 1'b1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
